// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU issue/capture stage and its neighbours.
//   - ALU_W / ALU_OPW : default operand and op-code widths of the downstream ALU
//   - ALU_ADD..ALU_EQ : ALU op-code constants
//   - state_t         : issue/capture FSM state encoding
//   - op_writes_acc   : which op codes update the accumulator
package alu_pkg;

    localparam int ALU_W   = 4;
    localparam int ALU_OPW = 3;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_LT  = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Compare ops produce flags, not data, so they must not clobber the accumulator.
    function automatic logic op_writes_acc(input logic [2:0] op);
        return (op <= ALU_XOR);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request and response handshakes of the ALU issue/capture stage.
//   request : in_valid/in_ready, in_op, in_a, in_b, in_acc
//   response: out_valid/out_ready, out_res, out_car, out_of, out_zero
//   slave modport is used by alu_seq, master modport by the producer/consumer side.
interface alu_seq_if #(
    parameter int W   = 4,
    parameter int OPW = 3
);
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_op;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_acc;

    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_res;
    logic           out_car;
    logic           out_of;
    logic           out_zero;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_acc, out_ready,
        output in_ready, out_valid, out_res, out_car, out_of, out_zero
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_acc, out_ready,
        input  in_ready, out_valid, out_res, out_car, out_of, out_zero
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: issue/capture stage in front of the combinational ALU.
//   clk, rst (sync, active high)
//   bus      : request/response handshakes (alu_seq_if.slave)
//   alu_a/alu_b/alu_ctrl : registered operands and op code driven to the ALU
//   alu_res/alu_car/alu_of : ALU outputs, captured at the end of EXEC
//   acc      : accumulator (last non-compare result)
//   op_cnt   : delivered-result counter, wraps modulo 2^CNTW
//   busy     : FSM is not IDLE
module alu_seq
    import alu_pkg::*;
#(
    parameter int W    = ALU_W,
    parameter int OPW  = ALU_OPW,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_seq_if.slave        bus,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [OPW-1:0]  alu_ctrl,
    input  logic [W-1:0]    alu_res,
    input  logic            alu_car,
    input  logic            alu_of,
    output logic [W-1:0]    acc,
    output logic [CNTW-1:0] op_cnt,
    output logic            busy
);

    state_t          state_q, state_d;
    logic [W-1:0]    alu_a_q, alu_a_d;
    logic [W-1:0]    alu_b_q, alu_b_d;
    logic [OPW-1:0]  alu_ctrl_q, alu_ctrl_d;
    logic [W-1:0]    out_res_q, out_res_d;
    logic            out_car_q, out_car_d;
    logic            out_of_q, out_of_d;
    logic            out_zero_q, out_zero_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CNTW-1:0] op_cnt_q, op_cnt_d;
    logic            in_ready_s;
    logic            take_s;
    logic [W-1:0]    op_a_s;

    // Ready: free in IDLE, or in HOLD when the held result leaves this same cycle.
    always_comb begin
        in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);
        take_s     = bus.in_valid && in_ready_s;
        op_a_s     = bus.in_acc ? acc_q : bus.in_a;
    end

    // Next-state and datapath updates for the IDLE/EXEC/HOLD sequence.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        out_res_d   = out_res_q;
        out_car_d   = out_car_q;
        out_of_d    = out_of_q;
        out_zero_d  = out_zero_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        op_cnt_d    = op_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (take_s) begin
                    alu_a_d    = op_a_s;
                    alu_b_d    = bus.in_b;
                    alu_ctrl_d = bus.in_op;
                    state_d    = ST_EXEC;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // ALU inputs have been stable for the whole cycle; sample its outputs.
                out_res_d   = alu_res;
                out_car_d   = alu_car;
                out_of_d    = alu_of;
                out_zero_d  = (alu_res == {W{1'b0}});
                out_valid_d = 1'b1;
                if (op_writes_acc(alu_ctrl_q)) begin
                    acc_d = alu_res;
                end else begin
                    acc_d = acc_q;
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    op_cnt_d    = op_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                    if (take_s) begin
                        // acc already holds the delivered result, so chaining works here.
                        alu_a_d    = op_a_s;
                        alu_b_d    = bus.in_b;
                        alu_ctrl_d = bus.in_op;
                        state_d    = ST_EXEC;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= {W{1'b0}};
            alu_b_q     <= {W{1'b0}};
            alu_ctrl_q  <= {OPW{1'b0}};
            out_res_q   <= {W{1'b0}};
            out_car_q   <= 1'b0;
            out_of_q    <= 1'b0;
            out_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= {W{1'b0}};
            op_cnt_q    <= {CNTW{1'b0}};
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            out_res_q   <= out_res_d;
            out_car_q   <= out_car_d;
            out_of_q    <= out_of_d;
            out_zero_q  <= out_zero_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_car   = out_car_q;
    assign bus.out_of    = out_of_q;
    assign bus.out_zero  = out_zero_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_ctrl      = alu_ctrl_q;
    assign acc           = acc_q;
    assign op_cnt        = op_cnt_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
